hasti_arbiter: RTL
==================

// Module: hasti_arbiter
// PURPOSE
//  Arbitration controller for a shared HASTI slave port reached by NM masters.
//  - Grants the address phase to one master per cycle.
//  - Tracks which master owns the data phase.
//  - Holds off losing masters and tells the slave-side mux when to register a
//    loser's address phase and replay it later.
//  Pure control: no address/data buses pass through this block.
// PARAMETERS
//  NM         2   number of masters sharing the slave (2..8)
//  LOCK_MAX  16   max cycles a locked sequence may hold the grant before forced release
// PORTS
//  hclk         in   1      bus clock
//  hresetn      in   1      asynchronous active-low reset
//  m_htrans     in   2*NM   htrans of each master (packed, master i at [2i+1:2i])
//  m_hmastlock  in   NM     hmastlock of each master
//  s_hreadyout  in   1      slave hreadyout
//  addr_grant   out  NM     one-hot: master whose address phase is on the slave this cycle
//  addr_valid   out  1      addr_grant carries a NONSEQ/SEQ transfer
//  hold_load    out  NM     capture master i's live address phase into its hold register
//  hold_sel     out  NM     slave address phase is taken from hold register i, not live master
//  data_owner   out  NM     one-hot: master whose data phase is in progress (0 = none)
//  m_hready     out  NM     hready returned to each master
// BEHAVIOUR
//  - Reset, async on hresetn low: addr_grant=0, addr_valid=0, hold_load=0,
//    hold_sel=0, data_owner=0, m_hready='1, pending=0, rr_ptr=0, lock_cnt=0.
//  - Request: master i requests when m_htrans[i] is NONSEQ (2'b10) or SEQ (2'b11)
//    and m_hready[i]=1, or when pending[i]=1. IDLE/BUSY never request.
//  - Arbitration: combinational in the cycle s_hreadyout=1.
//    - Round-robin order starts at rr_ptr.
//    - rr_ptr <= winner+1 (mod NM) on each accepted grant.
//    - No grant update while s_hreadyout=0; the address phase is frozen.
//  - Per-master state: IDLE, PEND.
//    - IDLE -> PEND: request accepted from the master (m_hready[i]=1) but master
//      loses arbitration or s_hreadyout=0. hold_load[i]=1 that cycle.
//    - PEND -> IDLE: master i granted with s_hreadyout=1. hold_sel[i]=1 that cycle.
//    - PEND holds a single transfer; m_hready[i]=0 while PEND, so no second capture.
//  - Data phase: on s_hreadyout=1, data_owner <= addr_grant & {NM{addr_valid}}.
//    Data-phase response goes to data_owner only.
//  - m_hready[i] = s_hreadyout when data_owner[i]=1, forced 0 while PEND, else 1.
//  - Lock:
//    - A winner with m_hmastlock=1 keeps the grant while its lock stays asserted,
//      even when other masters request.
//    - Release on the first cycle the lock master shows hmastlock=0.
//    - Release on lock_cnt==LOCK_MAX-1, which forces release and increments
//      rr_ptr past the lock master.
//  - Simultaneous events:
//    - A pending master and a live master request together: the pending one wins
//      if both are equal in RR order.
//    - A data phase ends (s_hreadyout=1) while a new grant is issued: both take
//      effect in the same edge.
//  - Latency: an uncontended master gets its grant in the same cycle (0 wait).
//    A contended master waits at most NM-1 transfers, plus the lock bound.
//  - Reset mid-transfer: all pending transfers are dropped. Masters must reissue.
// CONFIGURATION
//  HASTI_ARB_FIXED_PRIO_EN
//    defined:     fixed priority, lowest index wins; rr_ptr removed; lock logic unchanged.
//    not defined: round-robin as above.
// STRUCTURE
//  - hasti_pkg:
//    - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
//    - arb_state_t enum (ARB_IDLE, ARB_PEND).
//    - Constants HTRANS_NONSEQ and HTRANS_SEQ.
//  - Sub-module hasti_rr_pick: combinational one-hot round-robin picker
//    (req, ptr) -> grant. Also used under fixed priority with ptr tied to 0.
// TESTING
//  1. Single master 0 NONSEQ x4, s_hreadyout=1 ->
//     addr_grant=01 each cycle, no hold_load, data_owner=01 one cycle later.
//  2. Masters 0 and 1 both NONSEQ at cycle 0 ->
//     grant 01 at cycle 0, hold_load=10, m_hready[1]=0;
//     cycle 1: hold_sel=10, grant=10.
//  3. Two masters streaming, rr_ptr=0 -> grants alternate 01,10,01,10.
//     With HASTI_ARB_FIXED_PRIO_EN, master 0 streaming starves master 1.
//  4. s_hreadyout=0 for 3 cycles during master 1 data phase ->
//     m_hready[1]=0 for 3 cycles, grant frozen, m_hready[0] low only if PEND.
//  5. Master 0 locked burst of 20 beats, LOCK_MAX=16, master 1 requesting ->
//     forced release after 16 grants, then master 1 granted.
//  6. hresetn low while master 1 is PEND -> all outputs return to reset values
//     asynchronously; no hold_sel after reset release.

Source files
------------

// File: rtl/hasti_pkg.sv
// Shared types and constants for the HASTI slave-port arbiter.
package hasti_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PEND = 1'b1
  } arb_state_t;

  localparam logic [1:0] HTRANS_NONSEQ = NONSEQ;
  localparam logic [1:0] HTRANS_SEQ    = SEQ;

  // IDLE and BUSY never carry a transfer, so they never request the slave.
  function automatic logic is_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/hasti_arbiter_if.sv
// Control bundle between the masters' side and the arbiter; no address/data buses.
interface hasti_arbiter_if #(
  parameter int NM = 2
);
  import hasti_pkg::*;

  // A transfer moves onto the slave when addr_valid=1 and s_hreadyout=1 in the
  // same cycle; master i may change its address phase only when m_hready[i]=1.
  logic [2*NM-1:0] m_htrans;
  logic [NM-1:0]   m_hmastlock;
  logic            s_hreadyout;
  logic [NM-1:0]   addr_grant;
  logic            addr_valid;
  logic [NM-1:0]   hold_load;
  logic [NM-1:0]   hold_sel;
  logic [NM-1:0]   data_owner;
  logic [NM-1:0]   m_hready;
  arb_state_t      dbg_state [NM];

  modport master (
    output m_htrans, m_hmastlock, s_hreadyout,
    input  addr_grant, addr_valid, hold_load, hold_sel, data_owner, m_hready, dbg_state
  );

  modport slave (
    input  m_htrans, m_hmastlock, s_hreadyout,
    output addr_grant, addr_valid, hold_load, hold_sel, data_owner, m_hready, dbg_state
  );

endinterface

// File: rtl/hasti_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i wins (one-hot).
module hasti_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic [N-1:0] rot;
  logic [N-1:0] rgnt;

  // Rotate so the pointer position lands on bit 0, pick lowest, rotate back.
  always_comb begin
    rot = '0;
    for (int s = 0; s < N; s++) begin
      if (ptr_i == PW'(s)) begin
        for (int k = 0; k < N; k++) rot[k] = req_i[(s + k) % N];
      end
    end
  end

  assign rgnt = rot & (-rot);

  always_comb begin
    grant_o = '0;
    for (int s = 0; s < N; s++) begin
      if (ptr_i == PW'(s)) begin
        for (int k = 0; k < N; k++) grant_o[(s + k) % N] = rgnt[k];
      end
    end
  end

endmodule

// File: rtl/hasti_arbiter.sv
// Address/data-phase arbitration for one HASTI slave shared by NM masters.
// Define HASTI_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module hasti_arbiter
  import hasti_pkg::*;
#(
  parameter int NM       = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic           hclk,
  input  logic           hresetn,
  hasti_arbiter_if.slave bus
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  arb_state_t      state_q [NM];
  arb_state_t      state_d [NM];
  logic [NM-1:0]   rdy, live, req, pick, grant, hload, hsel;
  logic [NM-1:0]   grant_q, data_owner_q, lock_own_q;
  logic            valid, valid_q, hold;
  logic [CW-1:0]   lock_cnt_q;
  logic [PW-1:0]   ptr;

`ifdef HASTI_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_nxt;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  assign ptr_nxt = (win_idx == PW'(NM - 1)) ? '0 : win_idx + PW'(1);
  assign ptr     = rr_ptr_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                     rr_ptr_q <= '0;
    else if (bus.s_hreadyout && valid) rr_ptr_q <= ptr_nxt;
  end
`endif

  always_comb begin
    rdy  = '0;
    live = '0;
    req  = '0;
    for (int i = 0; i < NM; i++) begin
      rdy[i]  = data_owner_q[i] ? bus.s_hreadyout : (state_q[i] == ARB_IDLE);
      live[i] = is_active(bus.m_htrans[2*i +: 2]) && rdy[i];
      req[i]  = live[i] || (state_q[i] == ARB_PEND);
    end
  end

  hasti_rr_pick #(.N(NM), .PW(PW)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr),
    .grant_o (pick)
  );

  // A locked owner keeps the slave until it drops hmastlock or the budget expires.
  assign hold = (|(lock_own_q & bus.m_hmastlock)) && (lock_cnt_q != CW'(LOCK_MAX - 1));

  always_comb begin
    if (bus.s_hreadyout) begin
      grant = hold ? lock_own_q : pick;
      valid = |(grant & req);
    end else begin
      grant = grant_q;
      valid = valid_q;
    end
  end

  // Per-master FSM: state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < NM; i++) state_q[i] <= ARB_IDLE;
    end else begin
      for (int i = 0; i < NM; i++) state_q[i] <= state_d[i];
    end
  end

  // Per-master FSM: next state.
  always_comb begin
    for (int i = 0; i < NM; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ARB_IDLE: if (live[i] && !(bus.s_hreadyout && grant[i])) state_d[i] = ARB_PEND;
        ARB_PEND: if (bus.s_hreadyout && grant[i])               state_d[i] = ARB_IDLE;
        default:  state_d[i] = ARB_IDLE;
      endcase
    end
  end

  // Per-master FSM: outputs.
  always_comb begin
    hload = '0;
    hsel  = '0;
    for (int i = 0; i < NM; i++) begin
      hload[i] = (state_q[i] == ARB_IDLE) && live[i] && !(bus.s_hreadyout && grant[i]);
      hsel[i]  = (state_q[i] == ARB_PEND) && bus.s_hreadyout && grant[i];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      grant_q      <= '0;
      valid_q      <= 1'b0;
      data_owner_q <= '0;
      lock_own_q   <= '0;
      lock_cnt_q   <= '0;
    end else if (bus.s_hreadyout) begin
      grant_q      <= grant;
      valid_q      <= valid;
      data_owner_q <= grant & {NM{valid}};
      if (hold) begin
        lock_cnt_q <= lock_cnt_q + CW'(1);
      end else if (valid && (|(grant & bus.m_hmastlock))) begin
        lock_own_q <= grant;
        lock_cnt_q <= '0;
      end else begin
        lock_own_q <= '0;
        lock_cnt_q <= '0;
      end
    end
  end

  // Live-request paths are combinational, so they are masked while in reset.
  assign bus.addr_grant = grant & {NM{hresetn}};
  assign bus.addr_valid = valid & hresetn;
  assign bus.hold_load  = hload & {NM{hresetn}};
  assign bus.hold_sel   = hsel;
  assign bus.data_owner = data_owner_q;
  assign bus.m_hready   = rdy;
  assign bus.dbg_state  = state_q;

endmodule
